fetch_stage: RTL

- Instruction-fetch stage and IF/ID pipeline register feeding the control-decode unit.
- Holds the program counter, the link register and the instruction register.
- Presents the decoded opcode and fields to the decoder, and takes back the decoder's next-PC select and link-write strobe to steer fetch.
- Handles instruction-memory wait states, downstream stalls, branch flush and halt.

---
 rtl/fetch_if.sv | 38 +++
 rtl/fetch_stage.sv | 116 +++++++++++
 2 files changed

// File: rtl/fetch_if.sv
// fetch_if: bundles the instruction-memory, decoder-feedback and IF/ID
// outputs of the fetch stage.
//   master : used by fetch_stage (drives imem_addr and the ID-slot fields)
//   slave  : used by the environment (memory, decoder, hazard unit)
// Signals:
//   imem_addr/imem_data/imem_rdy : instruction-memory port
//   stall, pc_sel, lr_we         : downstream hold and decoder feedback
//   Oi, brx, id_rd, id_imm       : decoded fields of the ID-slot instruction
//   id_pc, id_valid, lr, halted  : ID-slot address/valid, link reg, halt flag
interface fetch_if #(
  parameter int IW = 16,
  parameter int AW = 8
);
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          imem_rdy;
  logic          stall;
  logic [1:0]    pc_sel;
  logic          lr_we;
  logic [3:0]    Oi;
  logic          brx;
  logic [2:0]    id_rd;
  logic [AW-1:0] id_imm;
  logic [AW-1:0] id_pc;
  logic          id_valid;
  logic [AW-1:0] lr;
  logic          halted;

  modport master (
    output imem_addr, Oi, brx, id_rd, id_imm, id_pc, id_valid, lr, halted,
    input  imem_data, imem_rdy, stall, pc_sel, lr_we
  );

  modport slave (
    input  imem_addr, Oi, brx, id_rd, id_imm, id_pc, id_valid, lr, halted,
    output imem_data, imem_rdy, stall, pc_sel, lr_we
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch plus IF/ID pipeline register.
// Holds PC, link register and instruction register; steers fetch from the
// decoder's pc_sel / lr_we feedback; handles imem wait states, stalls,
// redirect flush and HALT.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fetch_if.master (imem port, decoder feedback, ID-slot outputs)
//
// state | meaning
// BOOT  | first cycle after reset release, imem not sampled, PC held
// RUN   | normal fetch
// HALT  | HALT opcode reached, fetch frozen until reset
module fetch_stage #(
  parameter int         IW      = 16,
  parameter int         AW      = 8,
  parameter logic [3:0] NOP_OP  = 4'd0,
  parameter logic [3:0] HALT_OP = 4'd15
) (
  input logic      clk,
  input logic      rst_n,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] lr_q, lr_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [AW-1:0] id_pc_q, id_pc_d;
  logic          id_valid_q, id_valid_d;
  logic          halted_q, halted_d;

  logic [3:0]    ir_op;
  logic [AW-1:0] ir_imm;

  assign ir_op  = ir_q[IW-1 -: 4];
  assign ir_imm = ir_q[AW-1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    lr_d       = lr_q;
    ir_d       = ir_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    halted_d   = halted_q;

    unique case (state_q)
      BOOT: state_d = RUN;

      RUN: begin
        if (!bus.stall) begin
          if (id_valid_q && ir_op == HALT_OP) begin
            state_d    = HALT;
            halted_d   = 1'b1;
            id_valid_d = 1'b0;
          end else begin
            // Link write shares the edge with any redirect; a pc_sel=0
            // redirect below reads lr_q, i.e. the value before this write.
            if (id_valid_q && bus.lr_we)
              lr_d = id_pc_q + 1'b1;

            if (id_valid_q && (bus.pc_sel == 2'd0 || bus.pc_sel == 2'd2)) begin
              pc_d       = (bus.pc_sel == 2'd0) ? lr_q : ir_imm;
              id_valid_d = 1'b0;  // squash the word fetched this cycle
            end else if (bus.imem_rdy) begin
              ir_d       = bus.imem_data;
              id_pc_d    = pc_q;
              id_valid_d = 1'b1;
              pc_d       = pc_q + 1'b1;
            end else begin
              id_valid_d = 1'b0;
            end
          end
        end
      end

      HALT: id_valid_d = 1'b0;

      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= '0;
      lr_q       <= '0;
      ir_q       <= '0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      lr_q       <= lr_d;
      ir_q       <= ir_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.Oi        = id_valid_q ? ir_op : NOP_OP;
  assign bus.brx       = id_valid_q & ir_q[IW-5];
  assign bus.id_rd     = id_valid_q ? ir_q[IW-6 -: 3] : 3'd0;
  assign bus.id_imm    = id_valid_q ? ir_imm : '0;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.lr        = lr_q;
  assign bus.halted    = halted_q;

endmodule
